// File: rtl/riscv_pkg.sv
// riscv_pkg: ALU opcodes, forwarding select encoding and the ID/EX control bundle.
package riscv_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_EQ   = 4'b1000;
    localparam logic [3:0] ALU_ADDI = 4'b1100;

    typedef enum logic [1:0] {FWD_REG, FWD_EXM, FWD_WB} fwd_sel_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } id_ex_ctrl_t;
endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: picks the youngest in-flight producer of each source register.
module forwarding_unit import riscv_pkg::*; #(
    parameter int REG_IDX = 5
) (
    input  logic [REG_IDX-1:0] rs1,
    input  logic [REG_IDX-1:0] rs2,
    input  logic [REG_IDX-1:0] exm_rd,
    input  logic               exm_reg_write,
    input  logic [REG_IDX-1:0] wb_rd,
    input  logic               wb_reg_write,
    output fwd_sel_e           fwd_a,
    output fwd_sel_e           fwd_b
);
    function automatic fwd_sel_e sel(input logic [REG_IDX-1:0] r);
        return (r == '0) ? FWD_REG :
               (exm_reg_write && exm_rd == r) ? FWD_EXM :
               (wb_reg_write && wb_rd == r) ? FWD_WB : FWD_REG;
    endfunction

    assign fwd_a = sel(rs1);
    assign fwd_b = sel(rs2);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with ALU operand muxing and hazard stall; ID_EX_FORWARDING_EN enables bypassing.
module id_ex_stage import riscv_pkg::*; #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_IDX       = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_IDX-1:0]       id_rs1,
    input  logic [REG_IDX-1:0]       id_rs2,
    input  logic [REG_IDX-1:0]       id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_alu_src,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_mem_to_reg,
    input  logic                     flush,
    input  logic [REG_IDX-1:0]       exm_rd,
    input  logic                     exm_reg_write,
    input  logic [DATA_WIDTH-1:0]    exm_result,
    input  logic [REG_IDX-1:0]       wb_rd,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     stall,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     ex_valid,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_mem_to_reg,
    output logic [REG_IDX-1:0]       ex_rd
);
    id_ex_ctrl_t              ctrl, id_ctrl;
    logic [REG_IDX-1:0]       rs1, rs2;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    rs1_data, rs2_data, imm, opa, opb;
    logic                     hazard, bubble;

    assign id_ctrl = '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read,
                       mem_write: id_mem_write, mem_to_reg: id_mem_to_reg, alu_src: id_alu_src};
    assign bubble  = flush | stall | !id_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            rs1      <= '0;
            rs2      <= '0;
            ex_rd    <= '0;
            alu_op   <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            imm      <= '0;
        end else begin
            ctrl     <= bubble ? '0 : id_ctrl;
            rs1      <= bubble ? '0 : id_rs1;
            rs2      <= bubble ? '0 : id_rs2;
            ex_rd    <= bubble ? '0 : id_rd;
            alu_op   <= bubble ? '0 : id_alu_op;
            rs1_data <= bubble ? '0 : id_rs1_data;
            rs2_data <= bubble ? '0 : id_rs2_data;
            imm      <= bubble ? '0 : id_imm;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    fwd_sel_e sel_a, sel_b;

    forwarding_unit #(.REG_IDX(REG_IDX)) u_fwd (
        .rs1(rs1), .rs2(rs2), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .fwd_a(sel_a), .fwd_b(sel_b)
    );

    assign opa = (sel_a == FWD_EXM) ? exm_result : (sel_a == FWD_WB) ? wb_result : rs1_data;
    assign opb = (sel_b == FWD_EXM) ? exm_result : (sel_b == FWD_WB) ? wb_result : rs2_data;
    // Only a load result arrives too late to bypass.
    assign hazard = ctrl.valid & ctrl.mem_read & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
`else
    logic unused_fwd;
    logic raw1, raw2;

    assign unused_fwd = ^{exm_result, wb_rd, wb_reg_write, wb_result, rs1, rs2};
    assign opa  = rs1_data;
    assign opb  = rs2_data;
    // MEM/WB is covered by the write-before-read register file.
    assign raw1 = (id_rs1 != '0) & ((ctrl.valid & ctrl.reg_write & (ex_rd == id_rs1)) |
                                    (exm_reg_write & (exm_rd == id_rs1)));
    assign raw2 = (id_rs2 != '0) & ((ctrl.valid & ctrl.reg_write & (ex_rd == id_rs2)) |
                                    (exm_reg_write & (exm_rd == id_rs2)));
    assign hazard = id_valid & (raw1 | raw2);
`endif

    assign stall         = reset & hazard;
    assign SrcA          = opa;
    // ADDI hands the ALU its 12-bit immediate in the top bits; the ALU sign-extends it.
    assign SrcB          = (alu_op == OPCODE_LENGTH'(ALU_ADDI)) ? {imm[11:0], {(DATA_WIDTH-12){1'b0}}} :
                           ctrl.alu_src ? imm : opb;
    assign Operation     = alu_op;
    assign ex_store_data = opb;
    assign ex_valid      = ctrl.valid;
    assign ex_reg_write  = ctrl.reg_write;
    assign ex_mem_read   = ctrl.mem_read;
    assign ex_mem_write  = ctrl.mem_write;
    assign ex_mem_to_reg = ctrl.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table vectors, directed hazard sequences and a random run against an instruction-level model.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  op;
        logic        src, rw, mr, mw, mtr;
    } instr_t;

    typedef struct {
        instr_t      i;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] ea, eb, es;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        id_valid = 1'b0, id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0, id_mem_to_reg = 1'b0, flush = 1'b0;
    logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0]  id_alu_op = '0;
    logic [4:0]  exm_rd = '0, wb_rd = '0;
    logic        exm_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [31:0] exm_result = '0, wb_result = '0;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic [4:0]  ex_rd;

    int checks = 0, passed = 0;
    instr_t m;
    vec_t   tv[9];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .flush(flush), .exm_rd(exm_rd),
        .exm_reg_write(exm_reg_write), .exm_result(exm_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_result(wb_result), .stall(stall), .SrcA(SrcA),
        .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2, imm,
                                  input logic [3:0] op, input logic src);
        instr_t i = '{default: '0};
        i.valid = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.d1 = d1; i.d2 = d2; i.imm = imm; i.op = op; i.src = src;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.valid; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        id_rs1_data = i.d1; id_rs2_data = i.d2; id_imm = i.imm; id_alu_op = i.op;
        id_alu_src = i.src; id_reg_write = i.rw; id_mem_read = i.mr;
        id_mem_write = i.mw; id_mem_to_reg = i.mtr;
    endtask

    task automatic set_fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        exm_reg_write = xw; exm_rd = xrd; exm_result = xres;
        wb_reg_write = ww; wb_rd = wrd; wb_result = wres;
    endtask

    // Value the ALU should see for register r of the instruction in EX.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regval);
        if (FWD && r != 0 && exm_reg_write && exm_rd == r) return exm_result;
        if (FWD && r != 0 && wb_reg_write && wb_rd == r) return wb_result;
        return regval;
    endfunction

    function automatic logic depends_on(input logic [4:0] r);
        return id_valid && r != 0 && (r == id_rs1 || r == id_rs2);
    endfunction

    function automatic logic exp_stall();
        if (!reset) return 1'b0;
        if (FWD) return m.valid && m.mr && depends_on(m.rd);
        return (m.valid && m.rw && depends_on(m.rd)) || (exm_reg_write && depends_on(exm_rd));
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] eb;
        eb = (m.op == 4'b1100) ? {m.imm[11:0], 20'h0} : m.src ? m.imm : operand(m.rs2, m.d2);
        chk({tag, ".stall"}, stall, exp_stall());
        chk({tag, ".SrcA"}, SrcA, operand(m.rs1, m.d1));
        chk({tag, ".SrcB"}, SrcB, eb);
        chk({tag, ".Operation"}, Operation, m.op);
        chk({tag, ".store"}, ex_store_data, operand(m.rs2, m.d2));
        chk({tag, ".ex_valid"}, ex_valid, m.valid);
        chk({tag, ".ex_rd"}, ex_rd, m.rd);
        chk({tag, ".ctrl"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {m.rw, m.mr, m.mw, m.mtr});
    endtask

    initial begin
        instr_t add_i, lw_i, i;
        int n_stall;
        bit done;
        logic nxw;
        logic [4:0] nxrd;

        tv[0] = '{mk(1, 2, 3, 5, 7, 0, 4'b0010, 0), 0, 0, 0, 0, 0, 0, 5, 7, 7};
        tv[1] = '{mk(1, 2, 3, 'hAA, 7, 0, 4'b0010, 0), 1, 1, 'h10, 1, 1, 'h20, FWD ? 'h10 : 'hAA, 7, 7};
        tv[2] = '{mk(1, 2, 3, 'hAA, 7, 0, 4'b0010, 0), 0, 1, 'h10, 1, 1, 'h20, FWD ? 'h20 : 'hAA, 7, 7};
        tv[3] = '{mk(0, 0, 3, 'h55, 'h66, 0, 4'b0010, 0), 1, 0, 'h10, 1, 0, 'h20, 'h55, 'h66, 'h66};
        tv[4] = '{mk(1, 2, 3, 'h11, 'h77, 'h123, 4'b0010, 1), 1, 2, 'h30, 0, 0, 0, 'h11, 'h123, FWD ? 'h30 : 'h77};
        tv[5] = '{mk(1, 2, 3, 1, 2, 32'hFFFF_FFFD, 4'b1100, 1), 0, 0, 0, 0, 0, 0, 1, 32'hFFD0_0000, 2};
        tv[6] = '{mk(1, 2, 3, 1, 2, 'h7FF, 4'b1100, 0), 0, 0, 0, 0, 0, 0, 1, 32'h7FF0_0000, 2};
        tv[7] = '{mk(2, 3, 4, 9, 'h44, 0, 4'b0110, 0), 1, 9, 1, 1, 3, 'h50, 9, FWD ? 'h50 : 'h44, FWD ? 'h50 : 'h44};
        tv[8] = '{mk(1, 3, 4, 8, 'h44, 0, 4'b0001, 0), 1, 3, 'hA1, 1, 3, 'hB2, 8, FWD ? 'hA1 : 'h44, FWD ? 'hA1 : 'h44};

        add_i = mk(1, 2, 3, 5, 7, 0, 4'b0010, 0);
        add_i.rw = 1;
        lw_i = mk(2, 0, 1, 'h100, 0, 4, 4'b0010, 1);
        lw_i.rw = 1; lw_i.mr = 1; lw_i.mtr = 1;

        // Power-on reset: everything reads zero.
        #12;
        chk("por.stall", stall, 0);
        chk("por.SrcA", SrcA, 0);
        chk("por.ex_valid", ex_valid, 0);
        reset = 1'b1;

        // Reset asserted while decode is stalled on a load-use.
        tick;
        drive(lw_i);
        tick;
        drive(add_i);
        #1;
        chk("mid.stall_before", stall, 1);
        set_fwd(1, 1, 'h99, 1, 2, 'h98);
        reset = 1'b0;
        #1;
        chk("rst.stall", stall, 0);
        chk("rst.SrcA", SrcA, 0);
        chk("rst.SrcB", SrcB, 0);
        chk("rst.Operation", Operation, 0);
        chk("rst.store", ex_store_data, 0);
        chk("rst.ctrl", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
        chk("rst.ex_rd", ex_rd, 0);
        @(posedge clk);
        #2;
        set_fwd(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick;
        chk("post_rst.SrcA", SrcA, 5);
        chk("post_rst.SrcB", SrcB, 7);
        chk("post_rst.Operation", Operation, 4'b0010);
        chk("post_rst.ex_rd", ex_rd, 3);

        // Load-use: one stall cycle, one bubble, then the consumer loads.
        drive(lw_i);
        lw_i.rd = 4;
        drive(lw_i);
        tick;
        drive(mk(4, 1, 5, 0, 0, 0, 4'b0010, 0));
        #1;
        chk("lu.stall", stall, 1);
        tick;
        chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.stall_after", stall, 0);
        tick;
        chk("lu.loaded_valid", ex_valid, 1);
        chk("lu.loaded_rd", ex_rd, 5);

        // Flush coinciding with a stall still loads a bubble.
        drive(lw_i);
        tick;
        drive(mk(4, 1, 5, 0, 0, 0, 4'b0010, 0));
        flush = 1'b1;
        #1;
        chk("fl.stall", stall, 1);
        tick;
        flush = 1'b0;
        chk("fl.ctrl", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
        chk("fl.ex_rd", ex_rd, 0);
        tick;
        chk("fl.next_valid", ex_valid, 1);

        // Dependent ALU pair; the bench models EX/MEM and MEM/WB downstream.
        i = mk(1, 2, 5, 3, 4, 0, 4'b0010, 0);
        i.rw = 1;
        drive(i);
        tick;
        drive(mk(5, 1, 6, 0, 0, 0, 4'b0110, 0));
        n_stall = 0;
        done = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (!done && stall) n_stall++;
            if (id_valid && !stall) done = 1;
            nxw = ex_valid & ex_reg_write;
            nxrd = ex_rd;
            @(posedge clk);
            #1;
            set_fwd(nxw, nxrd, 'h7, exm_reg_write, exm_rd, exm_result);
            if (done) id_valid = 1'b0;
        end
        chk("raw.accepted", done, 1);
        chk("raw.stall_cycles", n_stall, FWD ? 0 : 2);

        // Table vectors: load, then apply bypass sources and check operands.
        set_fwd(0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
        tick;
        foreach (tv[k]) begin
            set_fwd(0, 0, 0, 0, 0, 0);
            drive(tv[k].i);
            tick;
            set_fwd(tv[k].xw, tv[k].xrd, tv[k].xres, tv[k].ww, tv[k].wrd, tv[k].wres);
            #1;
            chk($sformatf("tv%0d.SrcA", k), SrcA, tv[k].ea);
            chk($sformatf("tv%0d.SrcB", k), SrcB, tv[k].eb);
            chk($sformatf("tv%0d.store", k), ex_store_data, tv[k].es);
            chk($sformatf("tv%0d.Operation", k), Operation, tv[k].i.op);
        end

        // Random run from a clean reset against the instruction-level model.
        set_fwd(0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        m = '{default: '0};
        tick;
        for (int n = 0; n < 400; n++) begin
            i.valid = ($urandom_range(7) != 0);
            i.rs1 = 5'($urandom_range(3)); i.rs2 = 5'($urandom_range(3)); i.rd = 5'($urandom_range(3));
            i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
            i.op = ($urandom_range(3) == 0) ? 4'b1100 : 4'($urandom_range(15));
            i.src = 1'($urandom_range(1)); i.rw = 1'($urandom_range(1));
            i.mr = ($urandom_range(3) == 0); i.mw = 1'($urandom_range(1)); i.mtr = 1'($urandom_range(1));
            drive(i);
            flush = ($urandom_range(7) == 0);
            set_fwd(1'($urandom_range(1)), 5'($urandom_range(3)), $urandom,
                    1'($urandom_range(1)), 5'($urandom_range(3)), $urandom);
            #1;
            check_all("rnd");
            done = flush || exp_stall() || !i.valid;
            @(posedge clk);
            m = done ? '{default: '0} : i;
            #1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
